axi_slv_wr_responder: RTL and testbench

AXI3-style write-path slave responder for the traffic-generation testbench; it faces the master write-data driver across the AW/W/B channels. It queues accepted write addresses (up to `SLV_OSTDREQ_NUM` outstanding) and consumes W beats in address order. It checks each burst's beat count and WID against the queued address, then returns one B response per burst with the matching ID. Protocol violations are answered with SLVERR and counted.

---
 rtl/axi_slv_wr_responder_pkg.sv | 14 +
 rtl/axi_slv_wr_responder_if.sv | 32 +++
 rtl/axi_slv_wr_responder_fifo.sv | 41 ++++
 rtl/axi_slv_wr_responder.sv | 61 ++++++
 tb/tb_axi_slv_wr_responder.sv | 129 ++++++++++++
 5 files changed

// File: rtl/axi_slv_wr_responder_pkg.sv
// axi_slv_pkg: shared types for the AXI3 write-path slave responder.
package axi_slv_pkg;
   localparam int LEN_W = 4;
   localparam int ID_W = 4;
   typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [ID_W-1:0] id;
   } aw_entry_t;
   typedef struct packed {
      logic [ID_W-1:0] id;
      resp_t resp;
   } b_entry_t;
endpackage

// File: rtl/axi_slv_wr_responder_if.sv
// axi_slv_wr_responder_if: AW/W/B channel bundle between write master and slave responder.
interface axi_slv_wr_responder_if #(
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_ID_W = 4,
   parameter int AXI_DATA_W = 32
);
   logic in_awvalid;
   logic out_awready;
   logic [AXI_ADDR_W-1:0] in_awaddr;
   logic [3:0] in_awlen;
   logic [AXI_ID_W-1:0] in_awid;
   logic in_wvalid;
   logic out_wready;
   logic [AXI_ID_W-1:0] in_wid;
   logic [AXI_DATA_W-1:0] in_wdata;
   logic [AXI_DATA_W/8-1:0] in_wstrb;
   logic in_wlast;
   logic out_bvalid;
   logic in_bready;
   logic [AXI_ID_W-1:0] out_bid;
   logic [1:0] out_bresp;
   modport slave (
      input in_awvalid, in_awaddr, in_awlen, in_awid,
      input in_wvalid, in_wid, in_wdata, in_wstrb, in_wlast, in_bready,
      output out_awready, out_wready, out_bvalid, out_bid, out_bresp
   );
   modport master (
      output in_awvalid, in_awaddr, in_awlen, in_awid,
      output in_wvalid, in_wid, in_wdata, in_wstrb, in_wlast, in_bready,
      input out_awready, out_wready, out_bvalid, out_bid, out_bresp
   );
endinterface

// File: rtl/axi_slv_wr_responder_fifo.sv
// axi_sync_fifo: synchronous FIFO with registered storage, full/empty flags and wrapping pointers.
module axi_sync_fifo #(
   parameter int W = 8,
   parameter int DEPTH = 4
) (
   input logic aclk,
   input logic aresetn,
   input logic push,
   input logic pop,
   input logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic do_push, do_pop;
   assign full = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
   assign dout = mem[rp];
   // a pop frees the slot, so a push into a full queue is allowed on the same edge
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wp] <= din;
            wp <= wp + AW'(1);
         end
         if (do_pop) rp <= rp + AW'(1);
         cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end
endmodule

// File: rtl/axi_slv_wr_responder.sv
// axi_slv_wr_responder: queues AW, checks W bursts against the head address, returns one B per burst.
module axi_slv_wr_responder
   import axi_slv_pkg::*;
#(
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_ID_W = 4,
   parameter int AXI_DATA_W = 32,
   parameter int SLV_OSTDREQ_NUM = 4
) (
   input logic aclk,
   input logic aresetn,
   axi_slv_wr_responder_if.slave bus,
   output logic [15:0] out_err_cnt
);
   aw_entry_t aw_in, aw_head;
   b_entry_t b_in, b_head;
   logic aw_full, aw_empty, b_full, b_empty;
   logic aw_hs, w_hs, b_hs, last_cnt, retire, bad;
   logic [3:0] beat_cnt;
   logic err_flag;
   resp_t resp;
   logic [AXI_ADDR_W+AXI_DATA_W+AXI_DATA_W/8-1:0] unused_bits;
   assign unused_bits = {bus.in_awaddr, bus.in_wdata, bus.in_wstrb};
   assign bus.out_awready = !aw_full;
   assign bus.out_wready = !aw_empty && !b_full;
   assign bus.out_bvalid = !b_empty;
   assign bus.out_bid = b_head.id;
   assign bus.out_bresp = b_head.resp;
   assign aw_hs = bus.in_awvalid && bus.out_awready;
   assign w_hs = bus.in_wvalid && bus.out_wready;
   assign b_hs = bus.out_bvalid && bus.in_bready;
   assign aw_in = '{len: bus.in_awlen, id: bus.in_awid};
   assign last_cnt = beat_cnt == aw_head.len;
   assign retire = w_hs && (bus.in_wlast || last_cnt);
   // wlast can only disagree with the count on the retiring beat
   assign bad = (bus.in_wlast != last_cnt) || (bus.in_wid != aw_head.id[AXI_ID_W-1:0]);
   assign resp = (err_flag || bad) ? SLVERR : OKAY;
   assign b_in = '{id: aw_head.id, resp: resp};
   axi_sync_fifo #(.W($bits(aw_entry_t)), .DEPTH(SLV_OSTDREQ_NUM)) u_aw_q (
      .aclk(aclk), .aresetn(aresetn), .push(aw_hs), .pop(retire),
      .din(aw_in), .dout(aw_head), .full(aw_full), .empty(aw_empty)
   );
   axi_sync_fifo #(.W($bits(b_entry_t)), .DEPTH(SLV_OSTDREQ_NUM)) u_b_q (
      .aclk(aclk), .aresetn(aresetn), .push(retire), .pop(b_hs),
      .din(b_in), .dout(b_head), .full(b_full), .empty(b_empty)
   );
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         beat_cnt <= '0;
         err_flag <= 1'b0;
         out_err_cnt <= '0;
      end else if (retire) begin
         beat_cnt <= '0;
         err_flag <= 1'b0;
         if (resp == SLVERR && out_err_cnt != 16'hFFFF) out_err_cnt <= out_err_cnt + 16'd1;
      end else if (w_hs) begin
         beat_cnt <= beat_cnt + 4'd1;
         err_flag <= err_flag || bad;
      end
   end
endmodule

// File: tb/tb_axi_slv_wr_responder.sv
// tb_axi_slv_wr_responder: cycle-by-cycle directed vectors with hand-computed expected outputs.
module tb_axi_slv_wr_responder;
   typedef struct {
      logic rst;
      logic awv;
      logic [3:0] awlen;
      logic [3:0] awid;
      logic wv;
      logic [3:0] wid;
      logic wl;
      logic br;
      logic e_awr;
      logic e_wr;
      logic e_bv;
      logic [3:0] e_bid;
      logic [1:0] e_resp;
      logic [15:0] e_err;
   } vec_t;
   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic [15:0] err_cnt;
   int total = 0;
   int nbad = 0;
   int row = 0;
   vec_t tbl[$];
   axi_slv_wr_responder_if bus ();
   axi_slv_wr_responder dut (.aclk(aclk), .aresetn(aresetn), .bus(bus), .out_err_cnt(err_cnt));
   always #5 aclk = ~aclk;
   function automatic vec_t v(logic rst, logic awv, logic [3:0] awlen, logic [3:0] awid,
                              logic wv, logic [3:0] wid, logic wl, logic br,
                              logic awr, logic wr, logic bv, logic [3:0] bid,
                              logic [1:0] resp, logic [15:0] err);
      vec_t r;
      r = '{rst, awv, awlen, awid, wv, wid, wl, br, awr, wr, bv, bid, resp, err};
      return r;
   endfunction
   task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
      total++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s row %0d: got %0h want %0h", n, row, act, exp);
      end
   endtask
   task automatic apply(vec_t t);
      @(negedge aclk);
      aresetn = !t.rst;
      bus.in_awvalid = t.awv;
      bus.in_awlen = t.awlen;
      bus.in_awid = t.awid;
      bus.in_awaddr = $urandom;
      bus.in_wvalid = t.wv;
      bus.in_wid = t.wid;
      bus.in_wlast = t.wl;
      bus.in_wdata = $urandom;
      bus.in_wstrb = 4'($urandom);
      bus.in_bready = t.br;
      @(posedge aclk);
      #1;
      chk("awready", 16'(bus.out_awready), 16'(t.e_awr));
      chk("wready", 16'(bus.out_wready), 16'(t.e_wr));
      chk("bvalid", 16'(bus.out_bvalid), 16'(t.e_bv));
      if (t.e_bv || t.rst) begin
         chk("bid", 16'(bus.out_bid), 16'(t.e_bid));
         chk("bresp", 16'(bus.out_bresp), 16'(t.e_resp));
      end
      chk("err_cnt", err_cnt, t.e_err);
      row++;
   endtask
   initial begin
      bus.in_awvalid = 0; bus.in_awlen = 0; bus.in_awid = 0; bus.in_awaddr = 0;
      bus.in_wvalid = 0; bus.in_wid = 0; bus.in_wlast = 0; bus.in_wdata = 0;
      bus.in_wstrb = 0; bus.in_bready = 0;
      //               rst awv len id wv wid wl br | awr wr bv bid resp err
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
      // single burst len 3 id 5
      tbl.push_back(v(0, 1, 3, 5, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 1, 5, 0, 1,  1, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 1, 5, 0, 1,  1, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 1, 5, 0, 1,  1, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 1, 5, 1, 1,  1, 0, 1, 5, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0));
      // early wlast on beat 3 of a len-7 burst
      tbl.push_back(v(0, 1, 7, 6, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 1, 6, 0, 1,  1, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 1, 6, 0, 1,  1, 1, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 1, 6, 1, 1,  1, 0, 1, 6, 2, 1));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1));
      // len-0 burst right after: OKAY only if beat_cnt restarted at 0; B held while bready=0
      tbl.push_back(v(0, 1, 0, 7, 0, 0, 0, 1,  1, 1, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 1, 7, 1, 0,  1, 0, 1, 7, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 7, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1));
      // missing wlast and wid mismatch, len 1 id 2
      tbl.push_back(v(0, 1, 1, 2, 0, 0, 0, 1,  1, 1, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 1, 3, 0, 1,  1, 1, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 1, 3, 0, 1,  1, 0, 1, 2, 2, 2));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 2));
      // four outstanding AWs, fifth stalls; B back-pressure fills the B queue
      tbl.push_back(v(0, 1, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2));
      tbl.push_back(v(0, 1, 0, 2, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2));
      tbl.push_back(v(0, 1, 0, 3, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2));
      tbl.push_back(v(0, 1, 0, 4, 0, 0, 0, 0,  0, 1, 0, 0, 0, 2));
      tbl.push_back(v(0, 1, 0, 5, 1, 1, 1, 0,  1, 1, 1, 1, 0, 2));
      tbl.push_back(v(0, 1, 0, 5, 1, 2, 1, 0,  1, 1, 1, 1, 0, 2));
      tbl.push_back(v(0, 0, 0, 0, 1, 3, 1, 0,  1, 1, 1, 1, 0, 2));
      tbl.push_back(v(0, 0, 0, 0, 1, 4, 1, 0,  1, 0, 1, 1, 0, 2));
      tbl.push_back(v(0, 0, 0, 0, 1, 5, 1, 0,  1, 0, 1, 1, 0, 2));
      tbl.push_back(v(0, 0, 0, 0, 1, 5, 1, 1,  1, 1, 1, 2, 0, 2));
      tbl.push_back(v(0, 0, 0, 0, 1, 5, 1, 1,  1, 0, 1, 3, 0, 2));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 4, 0, 2));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 5, 0, 2));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 2));
      foreach (tbl[i]) apply(tbl[i]);
      // reset after 2 of 4 beats: aborted burst must never produce a B
      apply(v(0, 1, 3, 9, 0, 0, 0, 1,  1, 1, 0, 0, 0, 2));
      apply(v(0, 0, 0, 0, 1, 9, 0, 1,  1, 1, 0, 0, 0, 2));
      apply(v(0, 0, 0, 0, 1, 9, 0, 1,  1, 1, 0, 0, 0, 2));
      apply(v(1, 0, 0, 0, 1, 9, 0, 1,  1, 0, 0, 0, 0, 0));
      apply(v(0, 0, 0, 0, 1, 9, 0, 1,  1, 0, 0, 0, 0, 0));
      apply(v(0, 0, 0, 0, 1, 9, 1, 1,  1, 0, 0, 0, 0, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0));
      apply(v(0, 1, 0, 10, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0));
      apply(v(0, 0, 0, 0, 1, 10, 1, 1,  1, 0, 1, 10, 0, 0));
      apply(v(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0));
      $display("test done: total=%0d bad=%0d", total, nbad);
      $finish;
   end
endmodule
